address_decoder_prog: RTL and testbench

//  Registered bus-cycle address decoder for the PET memory map, with wait-state sequencing.

---
 rtl/address_decoder_prog_if.sv | 42 ++++
 rtl/address_decoder_prog.sv | 199 +++++++++++++++++++
 tb/tb_address_decoder_prog.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/address_decoder_prog_if.sv
// Bus-cycle and window-configuration signals for the PET address decoder.
// The slave side is the decoder; the master side is the bus sequencer / CPU glue.
interface address_decoder_prog_if #(
    parameter int ADDR_WIDTH  = 17,
    parameter int NUM_WINDOWS = 4,
    parameter int WAIT_WIDTH  = 3,
    parameter int IDX_W       = 2
);
    logic                   strobe;
    logic [ADDR_WIDTH-1:0]  addr;
    logic                   rw_b;
    logic                   cfg_we;
    logic [IDX_W-1:0]       cfg_sel;
    logic [ADDR_WIDTH-1:0]  cfg_base;
    logic [ADDR_WIDTH-1:0]  cfg_mask;
    logic [4:0]             cfg_attr;
    logic [WAIT_WIDTH-1:0]  cfg_wait;
    logic                   ram_enable;
    logic                   pia1_enable;
    logic                   pia2_enable;
    logic                   via_enable;
    logic                   crtc_enable;
    logic                   io_enable;
    logic                   ext_enable;
    logic                   mirror_enable;
    logic                   write_enable;
    logic [NUM_WINDOWS-1:0] window_hit;
    logic                   busy;
    logic                   ready;

    modport master (
        output strobe, addr, rw_b, cfg_we, cfg_sel, cfg_base, cfg_mask, cfg_attr, cfg_wait,
        input  ram_enable, pia1_enable, pia2_enable, via_enable, crtc_enable, io_enable,
               ext_enable, mirror_enable, write_enable, window_hit, busy, ready
    );

    modport slave (
        input  strobe, addr, rw_b, cfg_we, cfg_sel, cfg_base, cfg_mask, cfg_attr, cfg_wait,
        output ram_enable, pia1_enable, pia2_enable, via_enable, crtc_enable, io_enable,
               ext_enable, mirror_enable, write_enable, window_hit, busy, ready
    );
endinterface

// File: rtl/address_decoder_prog.sv
// Registered PET memory-map decoder with programmable override windows and
// per-region wait-state sequencing (IDLE -> WAIT -> DONE, one-cycle ready).
module address_decoder_prog #(
    parameter int ADDR_WIDTH  = 17,
    parameter int NUM_WINDOWS = 4,
    parameter int WAIT_WIDTH  = 3,
    parameter int IO_WAIT     = 2,
    parameter int IDX_W       = 2
) (
    input  logic                 clk,
    input  logic                 reset_b,
    address_decoder_prog_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    logic [NUM_WINDOWS-1:0] win_match;
    logic [3:0]             win_attr [NUM_WINDOWS];
    logic [WAIT_WIDTH-1:0]  win_wait [NUM_WINDOWS];
    logic                   cfg_sel_ok;

    assign cfg_sel_ok = ({1'b0, bus.cfg_sel} < (IDX_W+1)'(NUM_WINDOWS));

    // attr storage keeps {ram, permit_write, mirror, ext}; valid lives in its own reset flop
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WINDOWS; gi++) begin : g_win
            logic                  valid_reg;
            logic [ADDR_WIDTH-1:0] base_reg;
            logic [ADDR_WIDTH-1:0] mask_reg;
            logic [3:0]            attr_reg;
            logic [WAIT_WIDTH-1:0] wait_reg;
            logic                  wr_en;

            assign wr_en = bus.cfg_we && cfg_sel_ok && (bus.cfg_sel == IDX_W'(gi));

            always_ff @(posedge clk or negedge reset_b) begin
                if (!reset_b)
                    valid_reg <= 1'b0;
                else if (wr_en)
                    valid_reg <= bus.cfg_attr[4];
            end

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    base_reg <= bus.cfg_base;
                    mask_reg <= bus.cfg_mask;
                    attr_reg <= bus.cfg_attr[3:0];
                    wait_reg <= bus.cfg_wait;
                end
            end

            assign win_match[gi] = valid_reg && ((bus.addr & mask_reg) == (base_reg & mask_reg));
            assign win_attr[gi]  = attr_reg;
            assign win_wait[gi]  = wait_reg;
        end
    endgenerate

    logic                   dec_ram, dec_wr, dec_mirror, dec_ext;
    logic                   dec_pia1, dec_pia2, dec_via, dec_crtc;
    logic [WAIT_WIDTH-1:0]  dec_wait;
    logic [NUM_WINDOWS-1:0] dec_hit;

    always_comb begin
        dec_ram    = 1'b0;
        dec_wr     = 1'b0;
        dec_mirror = 1'b0;
        dec_ext    = 1'b0;
        dec_pia1   = 1'b0;
        dec_pia2   = 1'b0;
        dec_via    = 1'b0;
        dec_crtc   = 1'b0;
        dec_wait   = '0;
        dec_hit    = '0;
        if (|win_match) begin
            // isolate the lowest set bit: that window wins
            dec_hit = win_match & (~win_match + NUM_WINDOWS'(1));
            for (int i = NUM_WINDOWS - 1; i >= 0; i--) begin
                if (win_match[i]) begin
                    dec_ram    = win_attr[i][3];
                    dec_wr     = win_attr[i][2];
                    dec_mirror = win_attr[i][1];
                    dec_ext    = win_attr[i][0];
                    dec_wait   = win_wait[i];
                end
            end
        end else if (|bus.addr[ADDR_WIDTH-1:16]) begin
            dec_ram = 1'b1;
        end else if (!bus.addr[15]) begin
            dec_ram = 1'b1;
            dec_wr  = 1'b1;
        end else if (bus.addr[15:12] == 4'h8) begin
            dec_ram    = 1'b1;
            dec_wr     = 1'b1;
            dec_mirror = 1'b1;
        end else if (bus.addr[15:8] == 8'hE8) begin
            dec_wr   = 1'b1;
            dec_wait = WAIT_WIDTH'(IO_WAIT);
            case (bus.addr[7:4])
                4'h0: begin
                    dec_ram  = 1'b1;
                    dec_wait = '0;
                end
                4'h1:                   dec_pia1 = 1'b1;
                4'h2, 4'h3:             dec_pia2 = 1'b1;
                4'h4, 4'h5, 4'h6, 4'h7: dec_via  = 1'b1;
                default:                dec_crtc = 1'b1;
            endcase
        end else begin
            dec_ram = 1'b1;
        end
    end

    state_t                 state_reg;
    logic [WAIT_WIDTH-1:0]  cnt_reg;
    logic                   ram_reg, pia1_reg, pia2_reg, via_reg, crtc_reg;
    logic                   io_reg, ext_reg, mirror_reg, we_reg, busy_reg, ready_reg;
    logic [NUM_WINDOWS-1:0] hit_reg;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            ram_reg    <= 1'b0;
            pia1_reg   <= 1'b0;
            pia2_reg   <= 1'b0;
            via_reg    <= 1'b0;
            crtc_reg   <= 1'b0;
            io_reg     <= 1'b0;
            ext_reg    <= 1'b0;
            mirror_reg <= 1'b0;
            we_reg     <= 1'b0;
            hit_reg    <= '0;
            busy_reg   <= 1'b0;
            ready_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.strobe) begin
                        ram_reg    <= dec_ram;
                        pia1_reg   <= dec_pia1;
                        pia2_reg   <= dec_pia2;
                        via_reg    <= dec_via;
                        crtc_reg   <= dec_crtc;
                        io_reg     <= dec_pia1 | dec_pia2 | dec_via | dec_crtc;
                        ext_reg    <= dec_ext;
                        mirror_reg <= dec_mirror;
                        we_reg     <= dec_wr & ~bus.rw_b;
                        hit_reg    <= dec_hit;
                        busy_reg   <= 1'b1;
                        if (dec_wait != '0) begin
                            state_reg <= S_WAIT;
                            cnt_reg   <= dec_wait - WAIT_WIDTH'(1);
                        end else begin
                            state_reg <= S_DONE;
                            ready_reg <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_reg == '0) begin
                        state_reg <= S_DONE;
                        ready_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - WAIT_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    state_reg  <= S_IDLE;
                    ram_reg    <= 1'b0;
                    pia1_reg   <= 1'b0;
                    pia2_reg   <= 1'b0;
                    via_reg    <= 1'b0;
                    crtc_reg   <= 1'b0;
                    io_reg     <= 1'b0;
                    ext_reg    <= 1'b0;
                    mirror_reg <= 1'b0;
                    we_reg     <= 1'b0;
                    hit_reg    <= '0;
                    busy_reg   <= 1'b0;
                    ready_reg  <= 1'b0;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.ram_enable    = ram_reg;
    assign bus.pia1_enable   = pia1_reg;
    assign bus.pia2_enable   = pia2_reg;
    assign bus.via_enable    = via_reg;
    assign bus.crtc_enable   = crtc_reg;
    assign bus.io_enable     = io_reg;
    assign bus.ext_enable    = ext_reg;
    assign bus.mirror_enable = mirror_reg;
    assign bus.write_enable  = we_reg;
    assign bus.window_hit    = hit_reg;
    assign bus.busy          = busy_reg;
    assign bus.ready         = ready_reg;
endmodule

// File: tb/tb_address_decoder_prog.sv
// Self-checking bench for address_decoder_prog: directed map points plus randomized
// accesses and window programming against a range-based reference model.
module tb_address_decoder_prog;
    localparam int AW  = 17;
    localparam int NW  = 4;
    localparam int WW  = 3;
    localparam int IOW = 2;
    localparam int IW  = 2;

    typedef struct packed {
        logic [12:0] sel;
        logic [3:0]  wt;
    } exp_t;

    logic clk = 1'b0;
    logic reset_b = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    // reference window table
    logic          m_valid [NW];
    logic [AW-1:0] m_base  [NW];
    logic [AW-1:0] m_mask  [NW];
    logic [3:0]    m_attr  [NW];
    int            m_wait  [NW];

    always #5 clk = ~clk;

    address_decoder_prog_if #(.ADDR_WIDTH(AW), .NUM_WINDOWS(NW), .WAIT_WIDTH(WW), .IDX_W(IW)) bus ();

    address_decoder_prog #(
        .ADDR_WIDTH(AW), .NUM_WINDOWS(NW), .WAIT_WIDTH(WW), .IO_WAIT(IOW), .IDX_W(IW)
    ) dut (
        .clk(clk),
        .reset_b(reset_b),
        .bus(bus)
    );

    function automatic logic [12:0] dut_sel();
        return {bus.ram_enable, bus.pia1_enable, bus.pia2_enable, bus.via_enable,
                bus.crtc_enable, bus.io_enable, bus.ext_enable, bus.mirror_enable,
                bus.write_enable, bus.window_hit};
    endfunction

    function automatic exp_t model(input logic [AW-1:0] a, input logic rw);
        logic ram, p1, p2, via, crtc, ext, mir, perm;
        logic [NW-1:0] hit;
        int wt, win;
        exp_t e;
        {ram, p1, p2, via, crtc, ext, mir, perm} = '0;
        hit = '0;
        wt  = 0;
        win = -1;
        for (int i = 0; i < NW; i++)
            if (win < 0 && m_valid[i] && ((a & m_mask[i]) == (m_base[i] & m_mask[i])))
                win = i;
        if (win >= 0) begin
            ram  = m_attr[win][3];
            perm = m_attr[win][2];
            mir  = m_attr[win][1];
            ext  = m_attr[win][0];
            hit[win] = 1'b1;
            wt   = m_wait[win];
        end else if (a >= 'h10000) ram = 1'b1;
        else if (a < 'h8000) begin ram = 1'b1; perm = 1'b1; end
        else if (a < 'h9000) begin ram = 1'b1; perm = 1'b1; mir = 1'b1; end
        else if (a >= 'hE800 && a <= 'hE80F) begin ram = 1'b1; perm = 1'b1; end
        else if (a >= 'hE810 && a <= 'hE81F) begin p1 = 1'b1; perm = 1'b1; wt = IOW; end
        else if (a >= 'hE820 && a <= 'hE83F) begin p2 = 1'b1; perm = 1'b1; wt = IOW; end
        else if (a >= 'hE840 && a <= 'hE87F) begin via = 1'b1; perm = 1'b1; wt = IOW; end
        else if (a >= 'hE880 && a <= 'hE8FF) begin crtc = 1'b1; perm = 1'b1; wt = IOW; end
        else ram = 1'b1;
        e.sel = {ram, p1, p2, via, crtc, (p1 | p2 | via | crtc), ext, mir, perm & ~rw, hit};
        e.wt  = 4'(wt);
        return e;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NW; i++) m_valid[i] = 1'b0;
    endtask

    task automatic commit_cfg();
        int s;
        s = int'(bus.cfg_sel);
        if (s < NW) begin
            m_valid[s] = bus.cfg_attr[4];
            m_attr[s]  = bus.cfg_attr[3:0];
            m_base[s]  = bus.cfg_base;
            m_mask[s]  = bus.cfg_mask;
            m_wait[s]  = int'(bus.cfg_wait);
        end
    endtask

    task automatic set_cfg(input int sel, input logic [AW-1:0] base, input logic [AW-1:0] mask,
                           input logic [4:0] attr, input int wt);
        bus.cfg_sel  = IW'(sel);
        bus.cfg_base = base;
        bus.cfg_mask = mask;
        bus.cfg_attr = attr;
        bus.cfg_wait = WW'(wt);
    endtask

    task automatic rand_cfg();
        logic [AW-1:0] mask;
        case ($urandom_range(0, 4))
            0: mask = 17'h1FF00;
            1: mask = 17'h1F000;
            2: mask = 17'h1FFF0;
            3: mask = 17'h00000;
            default: mask = AW'($urandom);
        endcase
        set_cfg($urandom_range(0, NW - 1), AW'($urandom), mask,
                {($urandom_range(0, 2) != 0), 4'($urandom)}, $urandom_range(0, 7));
    endtask

    task automatic program_window(input int sel, input logic [AW-1:0] base, input logic [AW-1:0] mask,
                                  input logic [4:0] attr, input int wt);
        @(negedge clk);
        set_cfg(sel, base, mask, attr, wt);
        bus.cfg_we = 1'b1;
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
        commit_cfg();
    endtask

    // cfg_mode: 0 none, 1 cfg write in the strobe cycle, 2 cfg write in the first busy cycle
    task automatic do_access(input logic [AW-1:0] a, input logic rw, input int cfg_mode,
                             input bit hold, input string tag);
        exp_t e;
        @(negedge clk);
        e = model(a, rw);
        bus.strobe = 1'b1;
        bus.addr   = a;
        bus.rw_b   = rw;
        if (cfg_mode == 1) bus.cfg_we = 1'b1;
        @(posedge clk);
        #1;
        if (cfg_mode == 1) begin
            bus.cfg_we = 1'b0;
            commit_cfg();
        end
        if (hold) begin
            bus.addr = a ^ 17'h000F0;
            bus.rw_b = ~rw;
        end else begin
            bus.strobe = 1'b0;
        end
        for (int c = 0; c <= int'(e.wt); c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_sel() !== e.sel) begin
                n_fail++;
                $display("FAIL %s selects cycle %0d addr=%h: got %b expected %b", tag, c, a, dut_sel(), e.sel);
            end
            n_checks++;
            if (bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s busy cycle %0d addr=%h: got %b expected 1", tag, c, a, bus.busy);
            end
            n_checks++;
            if (bus.ready !== (c == int'(e.wt))) begin
                n_fail++;
                $display("FAIL %s ready cycle %0d addr=%h: got %b expected %b", tag, c, a, bus.ready, (c == int'(e.wt)));
            end
            if (cfg_mode == 2 && c == 0) begin
                bus.cfg_we = 1'b1;
                @(posedge clk);
                #1;
                bus.cfg_we = 1'b0;
                commit_cfg();
            end
        end
        @(negedge clk);
        n_checks++;
        if ({dut_sel(), bus.busy, bus.ready} !== 15'd0) begin
            n_fail++;
            $display("FAIL %s return-to-idle addr=%h: got %b expected 0", tag, a, {dut_sel(), bus.busy, bus.ready});
        end
        bus.strobe = 1'b0;
        $display("txn %s addr=%h rw_b=%b wait=%0d sel=%b cfg_mode=%0d hold=%0d", tag, a, rw, e.wt, e.sel, cfg_mode, hold);
    endtask

    task automatic test_reset();
        reset_b = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({dut_sel(), bus.busy, bus.ready} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0", {dut_sel(), bus.busy, bus.ready});
        end
        reset_b = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({dut_sel(), bus.busy, bus.ready} !== 15'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b expected 0", {dut_sel(), bus.busy, bus.ready});
        end
    endtask

    task automatic test_fixed_map();
        logic [AW-1:0] pts [0:17];
        pts = '{17'h07FFF, 17'h08000, 17'h08FFF, 17'h09000, 17'h0E7FF, 17'h0E800,
                17'h0E80F, 17'h0E81F, 17'h0E820, 17'h0E83F, 17'h0E87F, 17'h0E880,
                17'h0E8FF, 17'h0E900, 17'h10000, 17'h1E810, 17'h0FFFF, 17'h00000};
        do_access(17'h00123, 1'b0, 0, 0, "ram_write");
        do_access(17'h0E810, 1'b1, 0, 0, "pia1_read");
        do_access(17'h0C000, 1'b0, 0, 0, "rom_write");
        do_access(17'h08010, 1'b1, 0, 0, "vram_mirror");
        foreach (pts[i]) do_access(pts[i], 1'($urandom), 0, 0, "map_boundary");
    endtask

    task automatic test_strobe_busy();
        do_access(17'h0E840, 1'b0, 0, 1, "strobe_held_io");
        do_access(17'h00040, 1'b0, 0, 1, "strobe_held_ram");
    endtask

    task automatic test_reset_mid();
        program_window(2, 17'h00000, 17'h00000, 5'b10001, 1);
        @(negedge clk);
        bus.strobe = 1'b1;
        bus.addr   = 17'h0E810;
        bus.rw_b   = 1'b0;
        @(posedge clk);
        #1;
        bus.strobe = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b1 || bus.window_hit !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got busy=%b hit=%b expected busy=1 hit=0100", bus.busy, bus.window_hit);
        end
        #2 reset_b = 1'b0;
        #1;
        n_checks++;
        if ({dut_sel(), bus.busy, bus.ready} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %b expected 0", {dut_sel(), bus.busy, bus.ready});
        end
        clear_model();
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if ({dut_sel(), bus.busy, bus.ready} !== 15'd0) begin
                n_fail++;
                $display("FAIL reset_mid_no_ready cycle %0d: got %b expected 0", c, {dut_sel(), bus.busy, bus.ready});
            end
        end
        // table must be cleared: PIA1 decodes from the fixed map again
        do_access(17'h0E810, 1'b1, 0, 0, "after_reset_table_clear");
    endtask

    task automatic test_window();
        program_window(1, 17'h0E800, 17'h1FF00, 5'b10101, 4);
        do_access(17'h0E840, 1'b0, 0, 0, "window1_ext");
        do_access(17'h0E940, 1'b0, 0, 0, "window1_miss");
    endtask

    task automatic test_priority_race();
        program_window(0, 17'h01000, 17'h1F000, 5'b11000, 0);
        program_window(1, 17'h01000, 17'h1FF00, 5'b11100, 2);
        do_access(17'h01000, 1'b0, 0, 0, "priority_win0");
        set_cfg(0, 17'h01000, 17'h1F000, 5'b00000, 0);
        do_access(17'h01000, 1'b0, 1, 0, "race_cfg_same_cycle");
        do_access(17'h01000, 1'b0, 0, 0, "race_next_win1");
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        int mode;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                rand_cfg();
                program_window(int'(bus.cfg_sel), bus.cfg_base, bus.cfg_mask, bus.cfg_attr, int'(bus.cfg_wait));
            end
            case ($urandom_range(0, 3))
                0: a = AW'($urandom);
                1: a = 17'h0E800 | AW'($urandom_range(0, 255));
                2: a = m_base[$urandom_range(0, NW - 1)] ^ AW'($urandom_range(0, 3));
                default: a = AW'($urandom_range(0, 'hFFFF));
            endcase
            mode = $urandom_range(0, 2);
            if (mode != 0) rand_cfg();
            do_access(a, 1'($urandom), mode, ($urandom_range(0, 4) == 0), "random");
        end
    endtask

    initial begin
        bus.strobe   = 1'b0;
        bus.addr     = '0;
        bus.rw_b     = 1'b1;
        bus.cfg_we   = 1'b0;
        bus.cfg_sel  = '0;
        bus.cfg_base = '0;
        bus.cfg_mask = '0;
        bus.cfg_attr = '0;
        bus.cfg_wait = '0;
        for (int i = 0; i < NW; i++) begin
            m_base[i] = '0;
            m_mask[i] = '0;
            m_attr[i] = '0;
            m_wait[i] = 0;
        end
        test_reset();
        test_fixed_map();
        test_strobe_busy();
        test_reset_mid();
        test_window();
        test_priority_race();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
